// File: rtl/ifetch.sv
// Instruction-fetch sequencer: captures the PC on a fetch request, runs a read handshake
// to instruction memory, latches the returned word into ir and pulses pcinc on success.
`timescale 1ns/1ps
module ifetch #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_pc_addr,
    input  logic          i_fetch_req,
    input  logic          i_flush,
    input  logic          i_err_clr,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_data,
    output logic [DW-1:0] o_ir,
    output logic          o_ir_valid,
    output logic          o_pcinc,
    output logic          o_busy,
    output logic          o_fetch_err
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t        r_state,     w_state_next;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_next;
    logic          r_mem_rd,    w_mem_rd_next;
    logic [DW-1:0] r_ir,        w_ir_next;
    logic          r_ir_valid,  w_ir_valid_next;
    logic          r_pcinc,     w_pcinc_next;
    logic          r_busy,      w_busy_next;
    logic          r_fetch_err, w_fetch_err_next;
    logic [CW-1:0] r_cnt,       w_cnt_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_pcinc     <= 1'b0;
            r_busy      <= 1'b0;
            r_fetch_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_rd    <= w_mem_rd_next;
            r_ir        <= w_ir_next;
            r_ir_valid  <= w_ir_valid_next;
            r_pcinc     <= w_pcinc_next;
            r_busy      <= w_busy_next;
            r_fetch_err <= w_fetch_err_next;
            r_cnt       <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_mem_addr_next  = r_mem_addr;
        w_mem_rd_next    = r_mem_rd;
        w_ir_next        = r_ir;
        w_ir_valid_next  = r_ir_valid;
        w_pcinc_next     = 1'b0;
        w_busy_next      = r_busy;
        w_fetch_err_next = r_fetch_err;
        w_cnt_next       = r_cnt;

        case (r_state)
            S_IDLE: begin
                // A flush in the same cycle as a request wins; the request is dropped.
                if (i_flush) begin
                    w_ir_valid_next = 1'b0;
                end else if (i_fetch_req) begin
                    w_mem_addr_next = i_pc_addr;
                    w_mem_rd_next   = 1'b1;
                    w_busy_next     = 1'b1;
                    w_ir_valid_next = 1'b0;
                    w_cnt_next      = '0;
                    w_state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_mem_rd_next   = 1'b0;
                    w_busy_next     = 1'b0;
                    w_ir_valid_next = 1'b0;
                    w_state_next    = S_IDLE;
                end else if (i_mem_ready) begin
                    w_ir_next       = i_mem_data;
                    w_ir_valid_next = 1'b1;
                    w_pcinc_next    = 1'b1;
                    w_mem_rd_next   = 1'b0;
                    w_busy_next     = 1'b0;
                    w_state_next    = S_IDLE;
                end else begin
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                    // r_cnt counts earlier low cycles, so CNT_LAST marks the final allowed one.
                    if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                        w_fetch_err_next = 1'b1;
                        w_mem_rd_next    = 1'b0;
                        w_busy_next      = 1'b0;
                        w_state_next     = S_ERR;
                    end
                end
            end
            S_ERR: begin
                w_mem_rd_next = 1'b0;
                if (i_flush) begin
                    w_ir_valid_next = 1'b0;
                end
                if (i_err_clr) begin
                    w_fetch_err_next = 1'b0;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_ir        = r_ir;
    assign o_ir_valid  = r_ir_valid;
    assign o_pcinc     = r_pcinc;
    assign o_busy      = r_busy;
    assign o_fetch_err = r_fetch_err;

endmodule
